// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues single outstanding word reads,
// and presents fetched instructions to decode through a valid/stall handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_en,
    input  logic [31:0] br_target,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] old_addr;
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    logic        consumed;
    logic        out_free;

    assign consumed = if_valid && !id_stall;
    assign out_free = !if_valid || consumed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (br_en) begin
                    state_next = imem_resp ? FETCH : DISCARD;
                end else if (imem_resp && !out_free) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (br_en || consumed) begin
                    state_next = FETCH;
                end
            end
            DISCARD: begin
                if (imem_resp) begin
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    // DISCARD keeps presenting the stale address until the orphaned read completes.
    always_comb begin
        imem_read    = (state != HOLD);
        imem_address = (state == DISCARD) ? old_addr : pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            old_addr   <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            hold_instr <= '0;
            hold_pc    <= '0;
        end else begin
            if (consumed) begin
                if_valid <= 1'b0;
            end
            if (br_en) begin
                pc         <= {br_target[31:2], 2'b00};
                if_valid   <= 1'b0;
                hold_instr <= '0;
                hold_pc    <= '0;
                if (state == FETCH && !imem_resp) begin
                    old_addr <= pc;
                end
            end else begin
                case (state)
                    FETCH: begin
                        if (imem_resp) begin
                            pc <= pc + 32'd4;
                            if (out_free) begin
                                if_valid <= 1'b1;
                                if_instr <= imem_rdata;
                                if_pc    <= pc;
                            end else begin
                                hold_instr <= imem_rdata;
                                hold_pc    <= pc;
                            end
                        end
                    end
                    HOLD: begin
                        if (consumed) begin
                            if_valid <= 1'b1;
                            if_instr <= hold_instr;
                            if_pc    <= hold_pc;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven streaming/stall vectors plus
// hand-written redirect, reset and PC-wrap sequences against a small memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_en;
    logic [31:0] br_target;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp;
    logic [31:0] imem_rdata;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h00000060)) dut (
        .clk          (clk),
        .rst          (rst),
        .br_en        (br_en),
        .br_target    (br_target),
        .id_stall     (id_stall),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mem_lat = 1;
    bit          mem_mode = 1'b0;
    bit          mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = '0;

    typedef struct {
        bit          do_rst;
        bit          mode;
        bit          stall;
        bit          v;
        logic [31:0] pc;
        logic [31:0] instr;
        bit          rd;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs [13];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h60) return mem_mode ? 32'hAAAA0001 : 32'h00000013;
        if (a == 32'h64) return mem_mode ? 32'hAAAA0002 : 32'h00500093;
        return a ^ 32'h5A5A0000;
    endfunction

    task automatic mem_start();
        if (imem_read) begin
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imem_address;
        end
    endtask

    // One clock; the memory model answers mem_lat cycles after it first sees a request.
    task automatic tick();
        @(posedge clk);
        #1;
        if (imem_resp) begin
            imem_resp  = 1'b0;
            imem_rdata = '0;
            mem_busy   = 1'b0;
        end
        if (mem_busy) begin
            if (mem_cnt <= 1) begin
                imem_resp  = 1'b1;
                imem_rdata = mem_word(mem_addr);
            end else begin
                mem_cnt--;
            end
        end else begin
            mem_start();
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        br_en = 1'b0;
        tick();
        rst        = 1'b0;
        mem_busy   = 1'b0;
        imem_resp  = 1'b0;
        imem_rdata = '0;
        mem_start();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input bit v, input logic [31:0] pc,
                           input logic [31:0] instr, input bit rd, input logic [31:0] addr);
        chk({name, ".if_valid"}, {31'd0, if_valid}, {31'd0, v});
        if (v) begin
            chk({name, ".if_pc"}, if_pc, pc);
            chk({name, ".if_instr"}, if_instr, instr);
        end
        chk({name, ".imem_read"}, {31'd0, imem_read}, {31'd0, rd});
        if (rd) chk({name, ".imem_address"}, imem_address, addr);
    endtask

    initial begin
        rst        = 1'b1;
        br_en      = 1'b0;
        br_target  = '0;
        id_stall   = 1'b0;
        imem_resp  = 1'b0;
        imem_rdata = '0;

        // Streaming with 1-cycle memory, then stall held across two responses.
        vecs[0]  = '{1, 0, 0, 0, 32'h0,  32'h0,        1, 32'h60};
        vecs[1]  = '{0, 0, 0, 1, 32'h60, 32'h00000013, 1, 32'h64};
        vecs[2]  = '{0, 0, 0, 0, 32'h0,  32'h0,        1, 32'h64};
        vecs[3]  = '{0, 0, 0, 1, 32'h64, 32'h00500093, 1, 32'h68};
        vecs[4]  = '{0, 0, 0, 0, 32'h0,  32'h0,        1, 32'h68};
        vecs[5]  = '{1, 1, 1, 0, 32'h0,  32'h0,        1, 32'h60};
        vecs[6]  = '{0, 1, 1, 1, 32'h60, 32'hAAAA0001, 1, 32'h64};
        vecs[7]  = '{0, 1, 1, 1, 32'h60, 32'hAAAA0001, 1, 32'h64};
        vecs[8]  = '{0, 1, 1, 1, 32'h60, 32'hAAAA0001, 0, 32'h0};
        vecs[9]  = '{0, 1, 1, 1, 32'h60, 32'hAAAA0001, 0, 32'h0};
        vecs[10] = '{0, 1, 0, 1, 32'h64, 32'hAAAA0002, 1, 32'h68};
        vecs[11] = '{0, 1, 0, 0, 32'h0,  32'h0,        1, 32'h68};
        vecs[12] = '{0, 1, 0, 1, 32'h68, 32'h5A5A0068, 1, 32'h6C};

        mem_lat = 1;
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].do_rst) begin
                mem_mode = vecs[i].mode;
                id_stall = vecs[i].stall;
                do_reset();
                chk("reset.if_valid", {31'd0, if_valid}, 32'd0);
                chk("reset.if_pc", if_pc, 32'h0);
                chk("reset.if_instr", if_instr, 32'h0);
                chk_out("reset.req", 1'b0, 32'h0, 32'h0, 1'b1, 32'h60);
            end
            id_stall = vecs[i].stall;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].pc, vecs[i].instr,
                    vecs[i].rd, vecs[i].addr);
        end

        // Redirect while a 3-cycle read of 0x64 is outstanding.
        mem_mode = 1'b0; mem_lat = 3; id_stall = 1'b0;
        do_reset();
        repeat (4) tick();
        chk_out("disc.first", 1'b1, 32'h60, 32'h00000013, 1'b1, 32'h64);
        tick();
        chk_out("disc.pending", 1'b0, 32'h0, 32'h0, 1'b1, 32'h64);
        br_en = 1'b1; br_target = 32'h00000103;
        tick();
        br_en = 1'b0; mem_lat = 1;
        chk_out("disc.redirect", 1'b0, 32'h0, 32'h0, 1'b1, 32'h64);
        tick();
        chk_out("disc.stale", 1'b0, 32'h0, 32'h0, 1'b1, 32'h64);
        tick();
        chk_out("disc.newreq", 1'b0, 32'h0, 32'h0, 1'b1, 32'h100);
        repeat (2) tick();
        chk_out("disc.target", 1'b1, 32'h100, 32'h5A5A0100, 1'b1, 32'h104);

        // Redirect coincident with the response for 0x68.
        mem_mode = 1'b0; mem_lat = 1; id_stall = 1'b0;
        do_reset();
        repeat (5) tick();
        chk({"coinc.resp"}, {31'd0, imem_resp}, 32'd1);
        br_en = 1'b1; br_target = 32'h00000200;
        tick();
        br_en = 1'b0;
        chk_out("coinc.drop", 1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
        tick();
        chk_out("coinc.wait", 1'b0, 32'h0, 32'h0, 1'b1, 32'h200);
        tick();
        chk_out("coinc.target", 1'b1, 32'h200, 32'h5A5A0200, 1'b1, 32'h204);

        // Redirect in HOLD under stall still flushes the output register.
        mem_mode = 1'b1; id_stall = 1'b1;
        do_reset();
        repeat (4) tick();
        chk_out("holdbr.hold", 1'b1, 32'h60, 32'hAAAA0001, 1'b0, 32'h0);
        br_en = 1'b1; br_target = 32'h00000302;
        tick();
        br_en = 1'b0;
        chk_out("holdbr.flush", 1'b0, 32'h0, 32'h0, 1'b1, 32'h300);
        repeat (2) tick();
        chk_out("holdbr.target", 1'b1, 32'h300, 32'h5A5A0300, 1'b1, 32'h304);

        // Reset asserted in HOLD with a valid output.
        mem_mode = 1'b1; id_stall = 1'b1;
        do_reset();
        repeat (4) tick();
        chk_out("rsthold.hold", 1'b1, 32'h60, 32'hAAAA0001, 1'b0, 32'h0);
        do_reset();
        chk_out("rsthold.after", 1'b0, 32'h0, 32'h0, 1'b1, 32'h60);

        // PC wrap from 0xFFFFFFFC, reached by a redirect right after reset.
        mem_mode = 1'b0; id_stall = 1'b0;
        do_reset();
        br_en = 1'b1; br_target = 32'hFFFFFFFC;
        tick();
        br_en = 1'b0;
        chk_out("wrap.stale", 1'b0, 32'h0, 32'h0, 1'b1, 32'h60);
        tick();
        chk_out("wrap.req", 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFC);
        repeat (2) tick();
        chk_out("wrap.next", 1'b1, 32'hFFFFFFFC, 32'hA5A5FFFC, 1'b1, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end. Owns the PC, issues word reads to instruction memory, and delivers fetched instructions with their PCs into the instruction register / decode stage via a valid/stall handshake.
- It is the producer side of the IR load interface: if_valid && !id_stall is the decode-side load strobe.
- Handles downstream backpressure with a one-entry hold buffer, and handles control-flow redirects, including redirects that arrive while a memory read is still outstanding.

Parameters:
- RESET_PC, 32'h00000060, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- br_en  input  1  redirect request; takes effect this cycle
- br_target  input  32  redirect PC; bits [1:0] ignored and forced to 0
- id_stall  input  1  decode cannot accept; output register must hold
- if_valid  output  1  if_instr/if_pc hold a valid instruction
- if_instr  output  32  fetched instruction word
- if_pc  output  32  PC of if_instr
- imem_read  output  1  read request; held until imem_resp
- imem_address  output  32  read address; stable while imem_read is high
- imem_resp  input  1  read complete; imem_rdata valid this cycle
- imem_rdata  input  32  read data

Behaviour:
- Reset (rst=1 at an edge), regardless of state or any outstanding request:
  - pc=RESET_PC, state=FETCH.
  - if_valid=0, if_instr=0, if_pc=0, hold buffer empty.
  - An in-flight memory response is not tracked across reset; memory is reset together with this block.
- Registers:
  - pc (next fetch address).
  - Output register {if_valid, if_instr, if_pc}.
  - Hold buffer {hold_instr, hold_pc}.
  - state in {FETCH, HOLD, DISCARD}.
- Output consumption: "consumed" = if_valid && !id_stall in the current cycle. A consumed entry clears if_valid next cycle unless it is refilled in the same cycle.
- imem_read: 1 in FETCH and DISCARD, 0 in HOLD. imem_address=pc in FETCH.
  - In DISCARD, imem_address is the stale address latched when the redirect hit (old_addr), held stable until imem_resp.
- FETCH, imem_resp=1, br_en=0:
  - If the output register is empty or consumed: load if_instr=imem_rdata, if_pc=pc, if_valid=1; pc+=4; stay in FETCH. The next request is issued the following cycle.
  - Otherwise: hold buffer={imem_rdata, pc}; pc+=4; go to HOLD.
- FETCH, imem_resp=0: wait. Address is unchanged.
- HOLD:
  - When the output register is consumed: move the hold buffer into the output register (if_valid=1); go to FETCH.
- DISCARD:
  - On imem_resp: drop the data; go to FETCH. The new pc is issued the next cycle.
- Redirect (br_en=1) has priority over everything except rst:
  - pc=br_target & ~3; if_valid=0; hold buffer invalidated.
  - FETCH with imem_resp=0: latch old_addr=pc; go to DISCARD.
  - FETCH with imem_resp=1: drop the data; stay in FETCH.
  - HOLD: go to FETCH.
  - DISCARD: update pc to the newest target; stay in DISCARD, or go to FETCH if imem_resp=1.
- br_en with id_stall=1: the redirect still flushes the output register. Stall never blocks a redirect.
- Latency:
  - imem_resp at cycle N gives if_valid=1 at N+1.
  - With no stalls and zero-wait memory, throughput is one instruction per 2 cycles (request cycle plus response cycle, no overlap).
- PC arithmetic is 32-bit modulo: 0xFFFFFFFC+4 = 0x00000000.
- Invariant: never more than one outstanding memory read.

Test Plan:
- Reset, then memory responds in 1 cycle with 0x00000013 at 0x60 and 0x00500093 at 0x64; id_stall=0 -> imem_address=0x60 then 0x64; if_pc=0x60 (instr 0x00000013) then if_pc=0x64 (instr 0x00500093); if_valid pulses accordingly.
- id_stall=1 held across two responses, 0xAAAA0001 at 0x60 and 0xAAAA0002 at 0x64 -> output holds 0x60/0xAAAA0001; after the second response imem_read=0 (HOLD); release stall -> 0x64/0xAAAA0002 presented next cycle, then fetch of 0x68.
- br_en=1 with br_target=0x00000103 while a read of 0x64 is outstanding (3-cycle memory) -> if_valid=0; imem_address stays 0x64 until resp; that data never appears on if_instr; next request address is 0x100.
- br_en coincident with imem_resp for 0x68 -> data dropped; next imem_address is br_target; if_valid=0 the next cycle.
- rst asserted mid-HOLD with if_valid=1 -> next cycle if_valid=0, imem_read=1, imem_address=0x60.
- pc=0xFFFFFFFC fetched -> next imem_address=0x00000000.
